led_nios2_processor_oci_dct_packer: RTL and testbench

- Upstream neighbour of the OCI trace test bench; it produces the dct_buffer/dct_count pair that the bench consumes.
- It packs 2-bit direct-branch trace codes from the Nios II trace front end into a 30-bit compressed word of up to 15 slots.
- It emits a word when the word fills, on flush request, or when tracing stops.
- A one-entry output register with valid/ready decouples it from the trace-memory writer.

---
 rtl/led_nios2_oci_pkg.sv | 19 +
 rtl/led_nios2_processor_oci_dct_outreg.sv | 37 +++
 rtl/led_nios2_processor_oci_dct_packer.sv | 118 +++++++++++
 tb/tb_led_nios2_processor_oci_dct_packer.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/led_nios2_oci_pkg.sv
// Shared constants and types for the OCI direct-branch trace (DCT) packer.
package led_nios2_oci_pkg;

  localparam int DCT_SLOTS = 15;
  localparam int DCT_W     = 2 * DCT_SLOTS;
  localparam int DCT_CW    = 4;

  localparam logic [1:0] TC_NT  = 2'b00;
  localparam logic [1:0] TC_TK  = 2'b01;
  localparam logic [1:0] TC_EXC = 2'b10;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_FILL,
    ST_BLOCKED,
    ST_FLUSH
  } dct_state_t;

endpackage

// File: rtl/led_nios2_processor_oci_dct_outreg.sv
// One-entry valid/ready holding register for packed DCT words.
module led_nios2_processor_oci_dct_outreg
  import led_nios2_oci_pkg::*;
#(
  parameter int W  = DCT_W,
  parameter int CW = DCT_CW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [W-1:0]  load_buf,
  input  logic [CW-1:0] load_cnt,
  input  logic          take,
  output logic          valid,
  output logic [W-1:0]  buffer,
  output logic [CW-1:0] count,
  output logic          free
);

  // A word leaving this cycle frees the slot for a same-edge reload.
  assign free = !valid || take;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid  <= 1'b0;
      buffer <= '0;
      count  <= '0;
    end else if (load) begin
      valid  <= 1'b1;
      buffer <= load_buf;
      count  <= load_cnt;
    end else if (take) begin
      valid  <= 1'b0;
    end
  end

endmodule

// File: rtl/led_nios2_processor_oci_dct_packer.sv
// Packs 2-bit direct-branch trace codes into 15-slot words; emits on full, flush or trace stop.
module led_nios2_processor_oci_dct_packer
  import led_nios2_oci_pkg::*;
#(
  parameter int SLOTS = DCT_SLOTS,
  parameter int CNT_W = DCT_CW
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 trc_on,
  input  logic                 frame_valid,
  input  logic [1:0]           frame_data,
  output logic                 frame_ready,
  input  logic                 flush_req,
  output logic                 flush_ack,
  output logic [2*SLOTS-1:0]   dct_buffer,
  output logic [CNT_W-1:0]     dct_count,
  output logic                 dct_valid,
  input  logic                 dct_ready,
  output logic [7:0]           drop_cnt
);

  dct_state_t           state, state_nxt;
  logic [2*SLOTS-1:0]   acc_buf, acc_wr;
  logic [CNT_W-1:0]     acc_cnt, load_cnt;
  logic                 trc_q, armed;
  logic                 accept, fall, last, out_free, load, ack_set;

  assign fall        = trc_q && !trc_on;
  assign frame_ready = !reset && trc_on && (state == ST_EMPTY || state == ST_FILL);
  assign accept      = frame_valid && frame_ready;
  assign last        = accept && (acc_cnt == CNT_W'(SLOTS - 1));
  assign load_cnt    = acc_cnt + CNT_W'(accept);

  always_comb begin
    acc_wr = acc_buf;
    if (accept) acc_wr[{acc_cnt, 1'b0} +: 2] = frame_data;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= ST_EMPTY;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_EMPTY:   if (accept) state_nxt = flush_req ? ST_FLUSH : ST_FILL;
      ST_FILL: begin
        if (last)                    state_nxt = out_free ? ST_EMPTY : ST_BLOCKED;
        else if (flush_req || fall)  state_nxt = ST_FLUSH;
      end
      ST_BLOCKED: if (out_free) state_nxt = ST_EMPTY;
      ST_FLUSH:   if (out_free) state_nxt = ST_EMPTY;
      default:    state_nxt = ST_EMPTY;
    endcase
  end

  // An idle flush acks once per request level; a held request is re-armed only by dropping it.
  always_comb begin
    load    = 1'b0;
    ack_set = 1'b0;
    case (state)
      ST_EMPTY: ack_set = !accept && (fall || (flush_req && armed));
      ST_FILL: if (last && out_free) begin
        load    = 1'b1;
        ack_set = flush_req;
      end
      ST_BLOCKED: if (out_free) begin
        load    = 1'b1;
        ack_set = flush_req;
      end
      ST_FLUSH: if (out_free) begin
        load    = 1'b1;
        ack_set = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_buf   <= '0;
      acc_cnt   <= '0;
      trc_q     <= 1'b0;
      armed     <= 1'b1;
      flush_ack <= 1'b0;
      drop_cnt  <= '0;
    end else begin
      trc_q     <= trc_on;
      flush_ack <= ack_set;
      if (!flush_req)  armed <= 1'b1;
      else if (ack_set) armed <= 1'b0;
      if (load) begin
        acc_buf <= '0;
        acc_cnt <= '0;
      end else if (accept) begin
        acc_buf <= acc_wr;
        acc_cnt <= load_cnt;
      end
      if (frame_valid && !trc_on && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end
  end

  led_nios2_processor_oci_dct_outreg #(.W(2*SLOTS), .CW(CNT_W)) u_outreg (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .load_buf (acc_wr),
    .load_cnt (load_cnt),
    .take     (dct_ready),
    .valid    (dct_valid),
    .buffer   (dct_buffer),
    .count    (dct_count),
    .free     (out_free)
  );

endmodule

// File: tb/tb_led_nios2_processor_oci_dct_packer.sv
// Scoreboard bench: stimulus pushes expected words built from accepted codes; a monitor pops on handshake.
module tb_led_nios2_processor_oci_dct_packer;
  import led_nios2_oci_pkg::*;

  logic        clk = 1'b0, reset = 1'b1, trc_on = 1'b0;
  logic        frame_valid = 1'b0, flush_req = 1'b0;
  logic [1:0]  frame_data = 2'b00;
  logic        man_rdy = 1'b0, rnd_rdy = 1'b0, rnd_bit = 1'b0;
  logic        dct_ready;
  logic        frame_ready, flush_ack, dct_valid;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic [7:0]  drop_cnt;

  int          n_chk = 0, n_err = 0, ack_cnt = 0, waits = 0, drops_m = 0;
  logic [33:0] exp_q[$];
  logic [1:0]  cur[$];
  logic        hold_v = 1'b0;
  logic [33:0] hold_w = '0;

  assign dct_ready = rnd_rdy ? rnd_bit : man_rdy;

  led_nios2_processor_oci_dct_packer dut (
    .clk(clk), .reset(reset), .trc_on(trc_on), .frame_valid(frame_valid),
    .frame_data(frame_data), .frame_ready(frame_ready), .flush_req(flush_req),
    .flush_ack(flush_ack), .dct_buffer(dct_buffer), .dct_count(dct_count),
    .dct_valid(dct_valid), .dct_ready(dct_ready), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1 rnd_bit = 1'($urandom % 2);
  end

  task automatic chk(input string nm, input logic [33:0] act, input logic [33:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference word: code k of the current word sits in slot k, count = number of codes.
  task automatic emit_word();
    logic [33:0] w;
    if (cur.size() == 0) return;
    w = '0;
    foreach (cur[i]) w[2*i +: 2] = cur[i];
    w[33:30] = 4'(cur.size());
    exp_q.push_back(w);
    cur.delete();
  endtask

  always @(negedge clk) begin
    if (flush_ack) ack_cnt++;
    if (reset) hold_v = 1'b0;
    else begin
      if (hold_v) begin
        chk("hold_valid", 34'(dct_valid), 34'd1);
        chk("hold_word", {dct_count, dct_buffer}, hold_w);
      end
      if (dct_valid) begin
        chk("count_nonzero", 34'(dct_count != 4'd0), 34'd1);
        if (dct_ready) begin
          hold_v = 1'b0;
          if (exp_q.size() == 0) begin
            n_chk++; n_err++;
            $display("FAIL unexpected_word: got %0h expected none", {dct_count, dct_buffer});
          end else chk("word", {dct_count, dct_buffer}, exp_q.pop_front());
        end else begin
          hold_v = 1'b1;
          hold_w = {dct_count, dct_buffer};
        end
      end else hold_v = 1'b0;
    end
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send(input logic [1:0] c);
    logic acc;
    int   n;
    n = 0;
    frame_valid = 1'b1;
    frame_data  = c;
    acc = 1'b0;
    while (!acc && n < 300) begin
      @(negedge clk);
      acc = frame_ready;
      @(posedge clk); #1;
      if (!acc) begin n++; waits++; end
    end
    frame_valid = 1'b0;
    if (!acc) begin
      n_chk++; n_err++;
      $display("FAIL send_timeout: got no accept expected accept");
    end else begin
      cur.push_back(c);
      if (cur.size() == DCT_SLOTS) emit_word();
    end
  endtask

  task automatic flush();
    int a0, n;
    a0 = ack_cnt;
    n  = 0;
    flush_req = 1'b1;
    emit_word();
    while (ack_cnt == a0 && n < 500) begin @(posedge clk); #1; n++; end
    if (ack_cnt == a0) begin
      n_chk++; n_err++;
      $display("FAIL flush_timeout: got no flush_ack expected flush_ack");
    end
    flush_req = 1'b0;
    idle(1);
  endtask

  task automatic offer_off(input int n);
    logic fr;
    repeat (n) begin
      frame_valid = 1'b1;
      frame_data  = 2'($urandom);
      @(negedge clk);
      fr = frame_ready;
      @(posedge clk); #1;
      chk("off_ready", 34'(fr), 34'd0);
      if (drops_m < 255) drops_m++;
    end
    frame_valid = 1'b0;
  endtask

  task automatic trc_stop(input int n_off);
    trc_on = 1'b0;
    emit_word();
    offer_off(n_off);
    idle(1);
    trc_on = 1'b1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rst_valid", 34'(dct_valid), 34'd0);
    chk("rst_count", 34'(dct_count), 34'd0);
    chk("rst_buffer", 34'(dct_buffer), 34'd0);
    chk("rst_ack", 34'(flush_ack), 34'd0);
    chk("rst_ready", 34'(frame_ready), 34'd0);
    chk("rst_drop", 34'(drop_cnt), 34'd0);
    exp_q.delete();
    cur.delete();
    drops_m = 0;
    reset = 1'b0;
  endtask

  initial begin
    int a0, r;
    do_reset();

    // full word of alternating taken / not-taken with an always-ready consumer
    trc_on = 1'b1; man_rdy = 1'b1;
    idle(1);
    waits = 0;
    for (int i = 0; i < 15; i++) send((i % 2 == 0) ? TC_TK : TC_NT);
    chk("full_latency", 34'(dct_valid), 34'd1);
    chk("full_no_stall", 34'(waits), 34'd0);
    idle(2);

    // partial word by flush
    a0 = ack_cnt;
    send(TC_TK); send(TC_TK); send(TC_EXC);
    flush();
    idle(3);
    chk("flush_ack_once", 34'(ack_cnt - a0), 34'd1);

    // held output word, second word blocks, then both drain
    man_rdy = 1'b0;
    repeat (30) send(2'($urandom));
    chk("blocked_ready", 34'(frame_ready), 34'd0);
    idle(3);
    man_rdy = 1'b1;
    idle(4);
    chk("blocked_drained", 34'(exp_q.size()), 34'd0);

    // trace stop auto-flush plus dropped frames
    repeat (5) send(2'($urandom));
    trc_on = 1'b0;
    emit_word();
    offer_off(3);
    idle(3);
    chk("drop_three", 34'(drop_cnt), 34'(drops_m));
    trc_on = 1'b1;
    idle(3);

    // reset with a held word and a partial word pending
    man_rdy = 1'b0;
    repeat (22) send(2'($urandom));
    chk("pre_reset_valid", 34'(dct_valid), 34'd1);
    do_reset();
    man_rdy = 1'b1;
    send(TC_EXC);
    flush();
    idle(3);
    chk("post_reset_drained", 34'(exp_q.size()), 34'd0);

    // saturation of the drop counter
    trc_on = 1'b0;
    offer_off(300);
    chk("drop_sat", 34'(drop_cnt), 34'd255);
    trc_on = 1'b1;
    idle(2);

    // randomized mix with a randomly stalling consumer
    rnd_rdy = 1'b1;
    repeat (400) begin
      r = int'($urandom % 20);
      if (r < 14)      send(2'($urandom));
      else if (r < 16) flush();
      else if (r < 17) trc_stop(int'($urandom % 3));
      else             idle(int'($urandom % 3));
    end
    trc_stop(0);
    rnd_rdy = 1'b0;
    man_rdy = 1'b1;
    idle(10);
    chk("final_drained", 34'(exp_q.size()), 34'd0);
    chk("final_drop", 34'(drop_cnt), 34'(drops_m));

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule
